// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB-first, one bit per clock.
// Two operand shift registers feed a one-bit full_adder stage. A carry
// flip-flop closes the loop and an IDLE/SHIFT/DONE FSM sequences the work.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement
// overflow output 'ovf'.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sa, sb;
  logic [WIDTH-2:0]   acc;
  logic               c;
  logic [CNT_W-1:0]   cnt;
  logic               fs, fco;
  logic               load, last;
  logic [WIDTH-1:0]   acc_sh;

  full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (c),
    .s  (fs),
    .co (fco)
  );

  // A start in DONE chains straight into the next operation so that a
  // continuously held start yields one result every WIDTH+1 cycles.
  assign load   = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB; after the final shift this is the full sum.
  assign acc_sh = {fs, acc};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial shift/accumulate, and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      c   <= cin;
      cnt <= '0;
      acc <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= acc_sh[WIDTH-1:1];
      c   <= fco;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= acc_sh;
        cout <= fco;
`ifdef SERIAL_ADDER_OVF_EN
        // c is the carry into the MSB, fco the carry out of it.
        ovf  <= c ^ fco;
`endif
      end
    end
  end

endmodule
